timer_sched: RTL and testbench

TIMER_SCHED -- requirements
Module: timer_sched

---
 rtl/timer_sched.sv | 194 +++++++++++++++++++
 tb/tb_timer_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sched.sv
// timer_sched: round-robin scheduler that serves per-requester delay requests
// by programming, polling and stopping a shared timer over a simple
// SETUP/ACCESS bus.
module timer_sched #(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned timerbits     = 8,
  parameter int unsigned addrWidth     = 2,
  parameter int unsigned timerBaseAddr = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*timerbits-1:0] delay,
  output logic [NREQ-1:0]           done,
  output logic [NREQ-1:0]           err,
  output logic [NREQ-1:0]           grant,
  output logic                      sel,
  output logic                      enable,
  output logic                      write,
  output logic [addrWidth-1:0]      addr,
  output logic [timerbits-1:0]      wdata,
  input  logic [timerbits-1:0]      rdata,
  input  logic                      ready,
  input  logic                      slverr
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [addrWidth-1:0] AddrStatus = addrWidth'(timerBaseAddr);
  localparam logic [addrWidth-1:0] AddrGoal   = addrWidth'(timerBaseAddr + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_WR_GOAL, S_WR_START, S_POLL, S_WR_STOP, S_FINISH
  } state_e;

  // Bus phase inside a transfer state; GAP keeps sel low for one cycle.
  typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_e;

  state_e                 state_q;
  phase_e                 phase_q;
  logic [IdxW-1:0]        ptr_q;
  logic [IdxW-1:0]        gidx_q;
  logic [timerbits-1:0]   goal_q;
  logic                   abort_q;
  logic [NREQ-1:0]        done_q;
  logic [NREQ-1:0]        err_q;
  logic [NREQ-1:0]        grant_q;
  logic                   sel_q;
  logic                   enable_q;
  logic                   write_q;
  logic [addrWidth-1:0]   addr_q;
  logic [timerbits-1:0]   wdata_q;

  logic                   arb_found_c;
  logic [IdxW-1:0]        arb_idx_c;
  logic [timerbits-1:0]   arb_delay_c;
  logic [addrWidth-1:0]   xfer_addr_c;
  logic                   xfer_write_c;
  logic [timerbits-1:0]   xfer_wdata_c;
  logic                   unused_rdata_c;

  assign done   = done_q;
  assign err    = err_q;
  assign grant  = grant_q;
  assign sel    = sel_q;
  assign enable = enable_q;
  assign write  = write_q;
  assign addr   = addr_q;
  assign wdata  = wdata_q;

  // Only the completion field of STATUS is interpreted.
  assign unused_rdata_c = ^rdata;

  // Round-robin search starting at the pointer, wrapping at NREQ.
  always_comb begin : arb_comb
    int unsigned j;
    arb_found_c = 1'b0;
    arb_idx_c   = '0;
    j           = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = 32'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!arb_found_c && req[IdxW'(j)]) begin
        arb_found_c = 1'b1;
        arb_idx_c   = IdxW'(j);
      end
    end
  end

  // Goal value of the requester the arbiter is about to grant.
  always_comb begin
    arb_delay_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_idx_c == IdxW'(i)) arb_delay_c = delay[i*timerbits +: timerbits];
    end
  end

  // Transfer attributes implied by the current service step.
  always_comb begin
    xfer_addr_c  = AddrStatus;
    xfer_write_c = 1'b1;
    xfer_wdata_c = '0;
    unique case (state_q)
      S_WR_GOAL: begin
        xfer_addr_c  = AddrGoal;
        xfer_wdata_c = goal_q;
      end
      S_WR_START: xfer_wdata_c = timerbits'(1);
      S_POLL:     xfer_write_c = 1'b0;
      default:    ;
    endcase
  end

  // Scheduler FSM with bus sequencing and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      phase_q  <= PH_GAP;
      ptr_q    <= '0;
      gidx_q   <= '0;
      goal_q   <= '0;
      abort_q  <= 1'b0;
      done_q   <= '0;
      err_q    <= '0;
      grant_q  <= '0;
      sel_q    <= 1'b0;
      enable_q <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= AddrStatus;
      wdata_q  <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      unique case (state_q)
        S_IDLE: if (|req) state_q <= S_ARB;
        S_ARB: begin
          if (!arb_found_c) begin
            state_q <= S_IDLE;
          end else begin
            grant_q <= NREQ'(1) << arb_idx_c;
            gidx_q  <= arb_idx_c;
            goal_q  <= arb_delay_c;
            phase_q <= PH_GAP;
            state_q <= (arb_delay_c == '0) ? S_FINISH : S_WR_GOAL;
          end
        end
        S_WR_GOAL, S_WR_START, S_POLL, S_WR_STOP: begin
          unique case (phase_q)
            PH_GAP: begin
              sel_q    <= 1'b1;
              enable_q <= 1'b0;
              addr_q   <= xfer_addr_c;
              write_q  <= xfer_write_c;
              wdata_q  <= xfer_wdata_c;
              phase_q  <= PH_SETUP;
            end
            PH_SETUP: begin
              enable_q <= 1'b1;
              phase_q  <= PH_ACCESS;
            end
            PH_ACCESS: begin
              if (ready) begin
                sel_q    <= 1'b0;
                enable_q <= 1'b0;
                phase_q  <= PH_GAP;
                if (slverr) begin
                  abort_q <= 1'b1;
                  state_q <= (state_q == S_WR_STOP) ? S_FINISH : S_WR_STOP;
                end else begin
                  unique case (state_q)
                    S_WR_GOAL:  state_q <= S_WR_START;
                    S_WR_START: state_q <= S_POLL;
                    S_POLL:     if (rdata[3:2] == 2'b10) state_q <= S_WR_STOP;
                    default:    state_q <= S_FINISH;
                  endcase
                end
              end
            end
            default: phase_q <= PH_GAP;
          endcase
        end
        S_FINISH: begin
          if (abort_q) err_q[gidx_q]  <= 1'b1;
          else         done_q[gidx_q] <= 1'b1;
          grant_q <= '0;
          abort_q <= 1'b0;
          ptr_q   <= (gidx_q == IdxW'(NREQ - 1)) ? '0 : gidx_q + IdxW'(1);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed and randomized bench for timer_sched with a
// behavioural timer slave, bus protocol monitor and round-robin reference model.
module tb_timer_sched;

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_GOAL   = 2'd1;
  localparam logic [1:0] A_CURR   = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] delay = '0;
  logic [3:0]  done, err, grant;
  logic        sel, enable, write;
  logic [1:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ready, slverr;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] addr;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       serr;
    logic [3:0] gnt;
  } xfer_t;

  typedef struct {
    int idx;
    bit is_err;
  } ev_t;

  xfer_t xq[$];
  ev_t   evq[$];
  int    sel_cnt = 0;
  bit    inj_goal_err = 1'b0;
  int    mptr = 0;

  timer_sched #(.NREQ(4), .timerbits(8), .addrWidth(2), .timerBaseAddr(0)) dut (
    .clk(clk), .reset(reset), .req(req), .delay(delay),
    .done(done), .err(err), .grant(grant),
    .sel(sel), .enable(enable), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .slverr(slverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Timer slave: random wait states, counts up to GOAL once started.
  initial begin : slave
    bit          running;
    int unsigned curr, goal_reg;
    running = 0; curr = 0; goal_reg = 0;
    ready = 0; rdata = '0; slverr = 0;
    forever begin
      @(posedge clk); #1;
      ready = 0; slverr = 0;
      if (!reset) begin
        running = 0; curr = 0;
      end else begin
        if (running && curr < goal_reg) curr++;
        if (sel && enable && ($urandom_range(0, 2) != 0)) begin
          ready = 1;
          if (write && addr == A_GOAL && inj_goal_err) begin
            slverr = 1;
          end else if (write) begin
            if (addr == A_GOAL) goal_reg = 32'(wdata);
            else if (addr == A_STATUS) begin running = wdata[0]; curr = 0; end
          end else begin
            rdata = 8'($urandom);
            rdata[3:2] = (running && curr >= goal_reg) ? 2'b10 : (running ? 2'b01 : 2'b00);
          end
        end
      end
    end
  end

  // Protocol monitor and transfer/event logger.
  logic       p_sel = 0, p_en = 0, p_cmp = 0, p_wr = 0;
  logic [1:0] p_addr = '0;
  logic [7:0] p_wd = '0;
  always @(negedge clk) begin
    if (!reset) begin
      p_sel = 0; p_en = 0; p_cmp = 0;
    end else begin
      if (sel) sel_cnt++;
      chk("enable_only_with_sel", enable & ~sel, 0);
      if (sel && !p_sel) chk("setup_enable_low", enable, 0);
      if (sel && p_sel) begin
        chk("addr_stable", addr, p_addr);
        chk("write_stable", write, p_wr);
        chk("wdata_stable", wdata, p_wd);
      end
      if (p_sel && !p_en) chk("setup_one_cycle", {sel, enable}, 2'b11);
      if (p_cmp) chk("gap_after_xfer", sel, 0);
      chk("done_err_onehot0", $onehot0(done | err), 1);
      chk("done_and_err", |(done & err), 0);
      chk("grant_onehot0", $onehot0(grant), 1);
      if (sel && enable && ready) begin
        chk("no_curr_write", write && addr == A_CURR, 0);
        xq.push_back('{addr, write, wdata, rdata, slverr, grant});
      end
      for (int i = 0; i < 4; i++)
        if (done[i] | err[i]) evq.push_back('{i, err[i] & ~done[i]});
      p_sel = sel; p_en = enable; p_addr = addr; p_wr = write; p_wd = wdata;
      p_cmp = sel && enable && ready;
    end
  end

  task automatic pop_x(input string tag, output xfer_t x, output bit ok);
    ok = (xq.size() > 0);
    chk({tag, "_present"}, ok, 1);
    if (ok) x = xq.pop_front();
    else    x = '{default: '0};
  endtask

  task automatic expect_ev(input string tag, input int idx, input bit is_err);
    ev_t e;
    bit  ok;
    ok = (evq.size() > 0);
    chk({tag, "_present"}, ok, 1);
    if (ok) begin
      e = evq.pop_front();
      chk({tag, "_idx"}, e.idx, idx);
      chk({tag, "_kind"}, e.is_err, is_err);
    end
  endtask

  task automatic expect_wr(input string tag, input logic [1:0] a, input int d, input logic [3:0] g);
    xfer_t x;
    bit    ok;
    pop_x(tag, x, ok);
    if (ok) begin
      chk({tag, "_addr"}, x.addr, a);
      chk({tag, "_write"}, x.wr, 1);
      chk({tag, "_data"}, x.wdata, d);
      chk({tag, "_grant"}, x.gnt, g);
    end
  endtask

  // Expected bus history of one normal service, then its done pulse.
  task automatic verify_service(input int idx, input int d);
    xfer_t      x;
    bit         fin;
    logic [3:0] g;
    g = 4'(1 << idx);
    if (d != 0) begin
      expect_wr("goal_write", A_GOAL, d, g);
      expect_wr("start_write", A_STATUS, 1, g);
      fin = 0;
      while (!fin && xq.size() > 0 && !xq[0].wr) begin
        x = xq.pop_front();
        chk("poll_addr", x.addr, A_STATUS);
        chk("poll_grant", x.gnt, g);
        if (x.rdata[3:2] == 2'b10) fin = 1;
      end
      chk("poll_reached_complete", fin, 1);
      expect_wr("stop_write", A_STATUS, 0, g);
    end
    expect_ev("done_pulse", idx, 0);
  endtask

  task automatic serve(input logic [3:0] mask);
    int cyc;
    cyc = 0;
    @(negedge clk);
    req = req | mask;
    while (req != 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      req = req & ~(done | err);
    end
    chk("serve_in_time", req, 0);
    req = '0;
    @(negedge clk);
  endtask

  // Reference: simultaneous requests are served in rotation order from the pointer.
  task automatic run_round(input logic [3:0] mask, input int dl[4]);
    int ord[$];
    int idx;
    for (int i = 0; i < 4; i++) delay[i*8 +: 8] = 8'(dl[i]);
    for (int k = 0; k < 4; k++) begin
      idx = (mptr + k) % 4;
      if (mask[idx]) ord.push_back(idx);
    end
    serve(mask);
    foreach (ord[n]) verify_service(ord[n], dl[ord[n]]);
    if (ord.size() > 0) mptr = (ord[ord.size()-1] + 1) % 4;
    chk("round_no_extra_xfer", xq.size(), 0);
    chk("round_no_extra_event", evq.size(), 0);
  endtask

  initial begin : main
    int    dl[4];
    int    cyc;
    int    base;
    xfer_t x;
    bit    ok;

    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sel", sel, 0);
    chk("rst_enable", enable, 0);
    chk("rst_write", write, 0);
    chk("rst_addr", addr, A_STATUS);
    chk("rst_wdata", wdata, 0);
    reset = 1'b1;
    mptr = 0;

    // All four at once, then 0 and 2 after 3 has been served.
    dl = '{3, 3, 3, 3};
    run_round(4'b1111, dl);
    run_round(4'b0101, dl);

    // Single requester 0 with delay 5.
    dl = '{5, 0, 0, 0};
    run_round(4'b0001, dl);

    // Zero delay completes quickly with no bus activity.
    delay[23:16] = 8'd0;
    base = sel_cnt;
    @(negedge clk);
    req[2] = 1'b1;
    cyc = 0;
    while (!done[2] && cyc < 10) begin @(negedge clk); cyc++; end
    chk("zero_delay_latency_ok", cyc <= 3, 1);
    req[2] = 1'b0;
    @(negedge clk);
    chk("zero_delay_no_bus", sel_cnt - base, 0);
    verify_service(2, 0);
    mptr = 3;

    // Slave error on the GOAL write of requester 1.
    inj_goal_err = 1'b1;
    delay[15:8] = 8'd5;
    serve(4'b0010);
    inj_goal_err = 1'b0;
    pop_x("err_goal", x, ok);
    if (ok) begin
      chk("err_goal_addr", x.addr, A_GOAL);
      chk("err_goal_slverr", x.serr, 1);
    end
    expect_wr("err_stop_write", A_STATUS, 0, 4'b0010);
    expect_ev("err_pulse", 1, 1);
    chk("err_no_extra_event", evq.size(), 0);
    chk("err_no_extra_xfer", xq.size(), 0);
    mptr = 2;

    // Randomized rounds of simultaneous requests.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) dl[i] = $urandom_range(0, 9);
      run_round(4'($urandom_range(1, 15)), dl);
    end

    // Reset while requester 3 is polling, then full rerun.
    delay[31:24] = 8'd20;
    @(negedge clk);
    req[3] = 1'b1;
    cyc = 0;
    while (!(sel && !write) && cyc < 500) begin @(negedge clk); cyc++; end
    chk("reached_poll", sel && !write, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_enable", enable, 0);
    chk("mid_rst_write", write, 0);
    chk("mid_rst_addr", addr, A_STATUS);
    chk("mid_rst_wdata", wdata, 0);
    xq.delete();
    evq.delete();
    mptr = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    serve(4'b1000);
    verify_service(3, 20);
    chk("rerun_no_extra_event", evq.size(), 0);
    chk("rerun_no_extra_xfer", xq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
